// File: rtl/film_scanner_pkg.sv
// Shared types and constants for the film scanner FT245 line transmitter.
// Holds the packet FSM state encoding and the framing constants.
package film_scanner_pkg;

    localparam logic [7:0] FT_HDR0    = 8'hA5;
    localparam logic [7:0] FT_HDR1    = 8'h5A;
    // Header (2) + line number (2) + pixel count (2) + checksum (1)
    localparam int         FT_PKT_OVH = 7;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_LN_LO,
        ST_LN_HI,
        ST_PIX_LO,
        ST_PIX_HI,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_CHK
    } ft_tx_state_t;

endpackage

// File: rtl/ft_tx_byte.sv
// Single-entry output byte register for the FT245 synchronous FIFO write port.
// A byte stays on the bus with ft_wr low until the FT samples it with ft_txe low.
module ft_tx_byte (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       ft_txe,
    output logic       load_ok,
    output logic       accepted,
    output logic       ft_wr,
    output logic [7:0] ft_data_o,
    output logic       ft_data_oe
);

    logic       pend_reg;
    logic [7:0] byte_reg;

    assign accepted   = pend_reg && !ft_txe;
    // A new byte may be loaded in the same edge the pending one is taken.
    assign load_ok    = !pend_reg || !ft_txe;
    assign ft_wr      = ~pend_reg;
    assign ft_data_oe = pend_reg;
    assign ft_data_o  = byte_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg <= 1'b0;
            byte_reg <= 8'h00;
        end else if (load && load_ok) begin
            pend_reg <= 1'b1;
            byte_reg <= load_byte;
        end else if (accepted) begin
            pend_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ft_line_tx.sv
// Packs each scan line of 16-bit pixels into a framed packet
// (sync, line number, pixels, count, XOR checksum) on the FT245 sync FIFO bus.
module ft_line_tx
    import film_scanner_pkg::*;
#(
    parameter logic [7:0] HDR0 = FT_HDR0,
    parameter logic [7:0] HDR1 = FT_HDR1
) (
    input  logic        ft_clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [15:0] in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        ft_txe,
    output logic [7:0]  ft_data_o,
    output logic        ft_data_oe,
    output logic        ft_wr,
    output logic        ft_rd,
    output logic        ft_siwu,
    output logic        line_done,
    output logic        busy
);

    logic         rst_meta_reg;
    logic         rst_n_sync;

    ft_tx_state_t state_reg, state_next;
    logic [15:0]  line_num_reg;
    logic [15:0]  pix_cnt_reg;
    logic [7:0]   chk_reg;
    logic [7:0]   hi_byte_reg;
    logic         last_reg;
    logic         chk_sent_reg, chk_sent_next;
    logic         line_done_reg, done_next;

    logic         load;
    logic [7:0]   load_byte;
    logic         load_ok;
    logic         accepted;
    logic         start;
    logic         pix_hs;

    // Reset asserts immediately but releases two edges after nrst rises.
    always_ff @(posedge ft_clk or negedge nrst) begin
        if (!nrst) begin
            rst_meta_reg <= 1'b0;
            rst_n_sync   <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_n_sync   <= rst_meta_reg;
        end
    end

    ft_tx_byte u_byte (
        .clk        (ft_clk),
        .rst_n      (rst_n_sync),
        .load       (load),
        .load_byte  (load_byte),
        .ft_txe     (ft_txe),
        .load_ok    (load_ok),
        .accepted   (accepted),
        .ft_wr      (ft_wr),
        .ft_data_o  (ft_data_o),
        .ft_data_oe (ft_data_oe)
    );

    assign ft_rd     = 1'b1;
    assign ft_siwu   = 1'b1;
    assign line_done = line_done_reg;
    assign busy      = (state_reg != ST_IDLE) || ft_data_oe;
    assign start     = (state_reg == ST_IDLE) && en && in_valid;
    assign pix_hs    = (state_reg == ST_PIX_LO) && in_valid && load_ok;

    always_comb begin
        state_next    = state_reg;
        chk_sent_next = chk_sent_reg;
        done_next     = 1'b0;
        load          = 1'b0;
        load_byte     = 8'h00;
        in_ready      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_HDR0;
            end
            ST_HDR0: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = HDR0;
                    state_next = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = HDR1;
                    state_next = ST_LN_LO;
                end
            end
            ST_LN_LO: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = line_num_reg[7:0];
                    state_next = ST_LN_HI;
                end
            end
            ST_LN_HI: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = line_num_reg[15:8];
                    state_next = ST_PIX_LO;
                end
            end
            ST_PIX_LO: begin
                in_ready = load_ok;
                if (pix_hs) begin
                    load       = 1'b1;
                    load_byte  = in_data[7:0];
                    state_next = ST_PIX_HI;
                end
            end
            ST_PIX_HI: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = hi_byte_reg;
                    state_next = last_reg ? ST_CNT_LO : ST_PIX_LO;
                end
            end
            ST_CNT_LO: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = pix_cnt_reg[7:0];
                    state_next = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (load_ok) begin
                    load       = 1'b1;
                    load_byte  = pix_cnt_reg[15:8];
                    state_next = ST_CHK;
                end
            end
            ST_CHK: begin
                // Stay here until the checksum byte itself has left the register.
                if (!chk_sent_reg) begin
                    if (load_ok) begin
                        load          = 1'b1;
                        load_byte     = chk_reg;
                        chk_sent_next = 1'b1;
                    end
                end else if (accepted) begin
                    chk_sent_next = 1'b0;
                    done_next     = 1'b1;
                    state_next    = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ft_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_reg     <= ST_IDLE;
            chk_sent_reg  <= 1'b0;
            line_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            chk_sent_reg  <= chk_sent_next;
            line_done_reg <= done_next;
        end
    end

    always_ff @(posedge ft_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            line_num_reg <= 16'h0000;
            pix_cnt_reg  <= 16'h0000;
            chk_reg      <= 8'h00;
            hi_byte_reg  <= 8'h00;
            last_reg     <= 1'b0;
        end else begin
            if (start) begin
                chk_reg <= 8'h00;
            end else if (load && (state_reg != ST_CHK)) begin
                chk_reg <= chk_reg ^ load_byte;
            end
            if (start) begin
                pix_cnt_reg <= 16'h0000;
            end else if (pix_hs) begin
                pix_cnt_reg <= pix_cnt_reg + 16'd1;
                hi_byte_reg <= in_data[15:8];
                last_reg    <= in_last;
            end
            if (done_next) begin
                line_num_reg <= line_num_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ft_line_tx.sv
// Directed bench for ft_line_tx: line vectors with hand-computed packet bytes
// plus hand-written sequences for back-pressure, enable drop and reset.
module tb_ft_line_tx;

    logic        ft_clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_valid;
    logic        in_ready;
    logic        ft_txe;
    logic [7:0]  ft_data_o;
    logic        ft_data_oe;
    logic        ft_wr;
    logic        ft_rd;
    logic        ft_siwu;
    logic        line_done;
    logic        busy;

    ft_line_tx dut (
        .ft_clk     (ft_clk),
        .nrst       (nrst),
        .en         (en),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ft_txe     (ft_txe),
        .ft_data_o  (ft_data_o),
        .ft_data_oe (ft_data_oe),
        .ft_wr      (ft_wr),
        .ft_rd      (ft_rd),
        .ft_siwu    (ft_siwu),
        .line_done  (line_done),
        .busy       (busy)
    );

    always #5 ft_clk = ~ft_clk;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } pix_t;

    typedef struct {
        int          npix;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [15:0] line;
        logic [7:0]  chk;
    } line_vec_t;

    line_vec_t  vt [7];
    pix_t       src_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] cap_q [$];
    int         cap_cyc [$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         hs_cnt = 0;
    int         done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0].data;
            in_last  = src_q[0].last;
        end else begin
            in_valid = 1'b0;
            in_data  = 16'h0000;
            in_last  = 1'b0;
        end
    endtask

    // Observe on the falling edge what the next rising edge will act on,
    // then advance the pixel source just after the rising edge.
    task automatic step();
        logic hs;
        @(negedge ft_clk);
        if (!ft_wr && !ft_txe) begin
            cap_q.push_back(ft_data_o);
            cap_cyc.push_back(cyc);
        end
        hs = in_valid && in_ready;
        if (hs) hs_cnt++;
        if (line_done) done_cnt++;
        @(posedge ft_clk);
        #1;
        cyc++;
        if (hs && src_q.size() > 0) void'(src_q.pop_front());
        drive_src();
    endtask

    task automatic queue_line(input line_vec_t v);
        logic [15:0] p [3];
        pix_t        e;
        p[0] = v.p0;
        p[1] = v.p1;
        p[2] = v.p2;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(v.line[7:0]);
        exp_q.push_back(v.line[15:8]);
        for (int i = 0; i < v.npix; i++) begin
            e.data = p[i];
            e.last = (i == v.npix - 1);
            src_q.push_back(e);
            exp_q.push_back(p[i][7:0]);
            exp_q.push_back(p[i][15:8]);
        end
        exp_q.push_back(8'(v.npix));
        exp_q.push_back(8'(v.npix >> 8));
        exp_q.push_back(v.chk);
        drive_src();
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            step();
            n++;
        end
        check("line_done_count", done_cnt, target);
    endtask

    task automatic cmp_stream(input string name);
        check({name, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_byte%0d", name, i), cap_q[i], exp_q[i]);
        end
        $display("%s: %0d bytes captured, %0d expected", name, cap_q.size(), exp_q.size());
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
    endtask

    task automatic step_until_pending(input logic [7:0] b, input string name);
        int n = 0;
        while (!(ft_wr == 1'b0 && ft_data_o == b) && n < 100) begin
            step();
            n++;
        end
        check(name, {ft_wr, ft_data_o}, {1'b0, b});
    endtask

    initial begin
        int h0;
        int bad_rdy;
        int ncap;
        pix_t e;

        vt[0] = '{3, 16'h1234, 16'hABCD, 16'h00FF, 16'd0, 8'h43};
        vt[1] = '{3, 16'h1234, 16'hABCD, 16'h00FF, 16'd1, 8'h42};
        vt[2] = '{1, 16'hBEEF, 16'h0000, 16'h0000, 16'd2, 8'hAD};
        vt[3] = '{3, 16'h1234, 16'hABCD, 16'h00FF, 16'd3, 8'h40};
        vt[4] = '{3, 16'h1234, 16'hABCD, 16'h00FF, 16'd4, 8'h47};
        vt[5] = '{3, 16'h1234, 16'hABCD, 16'h00FF, 16'd5, 8'h46};
        vt[6] = '{3, 16'h1234, 16'hABCD, 16'h00FF, 16'd0, 8'h43};

        nrst   = 1'b0;
        en     = 1'b0;
        ft_txe = 1'b0;
        drive_src();
        repeat (3) @(posedge ft_clk);
        #1;
        check("rst_ft_wr", ft_wr, 1'b1);
        check("rst_ft_rd", ft_rd, 1'b1);
        check("rst_ft_siwu", ft_siwu, 1'b1);
        check("rst_data", ft_data_o, 8'h00);
        check("rst_oe", ft_data_oe, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_line_done", line_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        nrst = 1'b1;
        repeat (4) step();

        // Three lines queued back to back, including a single-pixel line.
        en = 1'b1;
        for (int i = 0; i < 3; i++) queue_line(vt[i]);
        wait_done(3, 400);
        if (cap_cyc.size() >= 13) check("first_13_consecutive", cap_cyc[12] - cap_cyc[0], 12);
        else check("first_13_present", cap_cyc.size(), 13);
        check("idle_busy", busy, 1'b0);
        check("idle_ft_wr", ft_wr, 1'b1);
        cmp_stream("b2b_lines");

        // FT full for 5 cycles while byte CD is pending.
        queue_line(vt[3]);
        step_until_pending(8'hCD, "reach_CD");
        ft_txe = 1'b1;
        ncap = cap_q.size();
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold_wr_data%0d", i), {ft_wr, ft_data_oe, ft_data_o}, {1'b0, 1'b1, 8'hCD});
        end
        check("hold_no_capture", cap_q.size(), ncap);
        ft_txe = 1'b0;
        wait_done(4, 200);
        cmp_stream("txe_hold");

        // Pixel offered while the FT is full in PIX_LO with a byte pending.
        queue_line(vt[4]);
        step_until_pending(8'h12, "reach_12");
        ft_txe = 1'b1;
        #1;
        check("stall_in_ready", in_ready, 1'b0);
        h0 = hs_cnt;
        repeat (3) step();
        check("stall_no_consume", hs_cnt, h0);
        check("stall_in_ready_after", in_ready, 1'b0);
        ft_txe = 1'b0;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        step();
        check("release_consume", hs_cnt, h0 + 1);
        wait_done(5, 200);
        cmp_stream("stall_pix");

        // Enable dropped after the first pixel: packet finishes, no new one.
        queue_line(vt[5]);
        h0 = 0;
        while (hs_cnt == 0 + hs_cnt - 0 && h0 < 100 && !(in_valid && in_ready)) begin
            step();
            h0++;
        end
        h0 = hs_cnt;
        step();
        check("en_first_pixel", hs_cnt, h0 + 1);
        en = 1'b0;
        wait_done(6, 200);
        cmp_stream("en_drop");
        e.data = 16'h5555;
        e.last = 1'b1;
        src_q.push_back(e);
        drive_src();
        bad_rdy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (in_ready !== 1'b0 || busy !== 1'b0) bad_rdy++;
        end
        check("en_off_ready_busy", bad_rdy, 0);
        check("en_off_no_bytes", cap_q.size(), 0);
        check("en_off_no_done", done_cnt, 6);
        src_q.delete();
        drive_src();

        // Reset while the high byte of a pixel is outstanding.
        en = 1'b1;
        e.data = 16'h1234;
        e.last = 1'b0;
        src_q.push_back(e);
        e.data = 16'hABCD;
        e.last = 1'b1;
        src_q.push_back(e);
        drive_src();
        step_until_pending(8'h34, "reach_34");
        nrst = 1'b0;
        #1;
        check("mid_rst_ft_wr", ft_wr, 1'b1);
        check("mid_rst_oe", ft_data_oe, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        src_q.delete();
        drive_src();
        repeat (2) step();
        cap_q.delete();
        cap_cyc.delete();
        exp_q.delete();
        nrst = 1'b1;
        repeat (4) step();
        queue_line(vt[6]);
        wait_done(7, 200);
        cmp_stream("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ft_line_tx.md
Name: ft_line_tx

Overview:
- Downstream consumer of the CCD pixel stream. Packs each scan line of 16-bit pixels into a framed byte packet and writes it to the FT245-style synchronous FIFO bus (FT232H) in the ft_clk domain.
- Pixels arrive through a valid/ready stream from the pixel CDC FIFO.
- Transmit-only: the read path is held idle.

Parameters:
- HDR0, 8'hA5: first sync byte.
- HDR1, 8'h5A: second sync byte.

Ports:
- ft_clk  in  1  FT-supplied 60 MHz clock; sole clock.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  enable new packets; sampled only in IDLE.
- in_data  in  16  pixel word.
- in_last  in  1  marks the final pixel of a line; qualified by in_valid.
- in_valid  in  1  pixel available.
- in_ready  out  1  pixel consumed when in_valid && in_ready at a clock edge.
- ft_txe  in  1  active-low; FT has space.
- ft_data_o  out  8  byte for ft_bus.
- ft_data_oe  out  1  ft_bus output enable; the top level builds the tristate.
- ft_wr  out  1  active-low write strobe.
- ft_rd  out  1  active-low read; constant 1.
- ft_siwu  out  1  constant 1.
- line_done  out  1  one-cycle pulse after the checksum byte is accepted.
- busy  out  1  state != IDLE or byte pending.

Behaviour:
- Reset values: ft_wr=1, ft_rd=1, ft_siwu=1, ft_data_o=0, ft_data_oe=0, in_ready=0, line_done=0, busy=0. Also line_num=0, pix_cnt=0, chk=0, pend=0, state=IDLE. Async assert, sync release.

Byte register:
- pend flag plus byte reg; ft_wr = ~pend; ft_data_oe = pend; ft_data_o = byte reg.
- accepted = pend && !ft_txe at the edge. The byte is then transferred; it is never duplicated or dropped.
- load_ok = !pend || accepted. Loading a new byte while load_ok sets pend=1; otherwise pend clears on accepted.
- Peak rate: 1 byte/clk while ft_txe=0.

FSM states: IDLE, HDR0, HDR1, LN_LO, LN_HI, PIX_LO, PIX_HI, CNT_LO, CNT_HI, CHK.
- IDLE: when en && in_valid, go to HDR0. The pixel is not consumed. Clear chk and pix_cnt.
- HDR0 through LN_HI: on load_ok, load HDR0, HDR1, line_num[7:0], line_num[15:8] in turn and advance.
- PIX_LO: in_ready = load_ok (combinational from ft_txe). On handshake:
  - load in_data[7:0];
  - latch in_data[15:8] and in_last;
  - pix_cnt += 1 (wraps mod 2^16);
  - go to PIX_HI.
- PIX_HI: on load_ok, load the latched high byte. Go to CNT_LO if the latched last flag is set, else PIX_LO.
- CNT_LO / CNT_HI: load pix_cnt low byte, then high byte.
- CHK: load chk. When that byte is accepted:
  - pulse line_done;
  - line_num += 1 (wraps 65535 to 0);
  - go to IDLE.
- chk = XOR of every byte loaded from HDR0 through CNT_HI, updated at load time.
- in_ready = 0 in every state except PIX_LO.

Boundaries:
- en falling mid-packet: the packet completes fully; no new packet starts.
- ft_txe high: byte and ft_wr hold stable indefinitely.
- in_valid low in PIX_LO: wait; no timeout.
- Single-pixel line (in_last on the first pixel): count byte pair is 01 00.
- nrst mid-packet: everything returns to reset values; the partial packet is abandoned; line_num restarts at 0.

Decomposition:
- film_scanner_pkg holds:
  - the state enum ft_tx_state_t;
  - localparams FT_HDR0 / FT_HDR1;
  - the packet overhead constant FT_PKT_OVH = 7.
- Sub-module ft_tx_byte: byte reg, pend, and the load_ok/accepted logic driving ft_wr, ft_data_o and ft_data_oe.
- The FSM and counters stay in ft_line_tx.

Test Plan:
- Pixels 16'h1234, 16'hABCD, 16'h00FF (last) with ft_txe=0, en=1 after reset.
  - Required bus bytes: A5 5A 00 00 34 12 CD AB FF 00 03 00 43.
  - 13 bytes on 13 consecutive accepting edges; line_done pulses once.
- Same line, but ft_txe held high for 5 cycles while byte CD is pending.
  - CD and ft_wr=0 stay stable for all 5 cycles.
  - The sequence is identical to the first test, with no duplicates.
- Two back-to-back lines.
  - Second header is A5 5A 01 00.
  - The second checksum is recomputed from scratch.
- Drop en after the first pixel is accepted.
  - The full packet still completes.
  - The next in_valid is ignored and in_ready stays 0.
- Assert nrst while in PIX_HI.
  - ft_wr=1 and ft_data_oe=0 immediately.
  - The next packet header is A5 5A 00 00.
- in_valid=1 while ft_txe=1 with pend set.
  - in_ready=0 and in_data is not consumed.
  - The pixel is consumed on the first edge after ft_txe=0.
